// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle MIPS main controller.
// Opcodes, state encodings, ALUop codes and the control bundle.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_IMMWB  = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_ORIEX  = 4'd12;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  // rdy_gate marks states whose ir/pc/mem write
  // strobes only fire once memory is ready.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       pc_write;
    logic       branch;
    logic       rdy_gate;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore decode: state -> raw control vector (ungated strobes).
// Ports: state in, ctrl out. Macro MC_ORI_EN enables ORIEX decode.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
#(
  parameter logic [1:0] RESET_PC_SRC = 2'b00
) (
  input  logic [3:0] state,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = RESET_PC_SRC;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.rdy_gate  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.rdy_gate  = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = 2'b01;
        ctrl.branch    = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_IMMWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src   = 2'b10;
        ctrl.pc_write = 1'b1;
      end
`ifdef MC_ORI_EN
      S_ORIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ORI;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main-control FSM: sequences fetch..writeback,
// drives datapath selects/strobes and ALUop. Macro MC_ORI_EN adds ori.
// Ports: clk, rst_n, opcode, zero, mem_ready in; ALUop, mux selects,
// strobes, pc_en, illegal_op, state out.
module mc_main_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter logic [1:0] RESET_PC_SRC = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ALUop,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       illegal;
  logic       gate;
  logic       pc_write;
  ctrl_t      ctrl;

  always_comb begin
    state_d = S_FETCH;
    illegal = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          opcode == OP_RTYPE: state_d = S_EXEC;
          opcode == OP_LW:    state_d = S_MEMADR;
          opcode == OP_SW:    state_d = S_MEMADR;
          opcode == OP_BEQ:   state_d = S_BRANCH;
          opcode == OP_ADDI:  state_d = S_ADDIEX;
          opcode == OP_J:     state_d = S_JUMP;
`ifdef MC_ORI_EN
          opcode == OP_ORI:   state_d = S_ORIEX;
`endif
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      // opcode is re-sampled here; anything but lw/sw aborts
      S_MEMADR: begin
        unique case (1'b1)
          opcode == OP_LW: state_d = S_MEMRD;
          opcode == OP_SW: state_d = S_MEMWR;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_IMMWB;
`ifdef MC_ORI_EN
      S_ORIEX:  state_d = S_IMMWB;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  mc_ctrl_outdec #(
    .RESET_PC_SRC(RESET_PC_SRC)
  ) u_outdec (
    .state(state_q),
    .ctrl (ctrl)
  );

  // Strobes are forced low while reset is held, even though
  // state_q already reads FETCH.
  assign gate       = ~ctrl.rdy_gate | mem_ready;
  assign pc_write   = ctrl.pc_write & gate;

  assign ALUop      = ctrl.alu_op;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign pc_src     = ctrl.pc_src;
  assign iord       = ctrl.iord;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign ir_write   = rst_n & ctrl.ir_write & gate;
  assign mem_read   = rst_n & ctrl.mem_read;
  assign mem_write  = rst_n & ctrl.mem_write & gate;
  assign reg_write  = rst_n & ctrl.reg_write;
  assign pc_en      = rst_n & (pc_write | (ctrl.branch & zero));
  assign illegal_op = rst_n & illegal & (state_q == S_DECODE);
  assign state      = state_q;

endmodule
